// File: rtl/oamdma_pkg.sv
// Shared types for the sprite-memory DMA sequencer.
// The optional DMC sample-fetch steal path is enabled by defining OAMDMA_DMC_EN.
package oamdma_pkg;

    localparam int unsigned NBYTES_DEF = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
`ifdef OAMDMA_DMC_EN
        ,
        ST_DMCRD,
        ST_DMCPUT
`endif
    } state_e;

endpackage

// File: rtl/oamdma_if.sv
// CPU-bus / OAM-port bundle for the sprite DMA; DMC steal signals exist only
// when OAMDMA_DMC_EN is defined.
interface oamdma_if;
    import oamdma_pkg::*;

    logic        cputick;
    logic        wr4014;
    logic [7:0]  regwdata;
    logic [7:0]  memrdata;
    logic        dmahalt;
    logic [15:0] dmaaddr;
    logic        dmard;
    logic        dmawr2004;
    logic [7:0]  dmawdata;
`ifdef OAMDMA_DMC_EN
    logic        dmcreq;
    logic [15:0] dmcaddr;
    logic        dmcack;
    logic [7:0]  dmcdata;

    modport master (
        output cputick, wr4014, regwdata, memrdata, dmcreq, dmcaddr,
        input  dmahalt, dmaaddr, dmard, dmawr2004, dmawdata, dmcack, dmcdata
    );
    modport slave (
        input  cputick, wr4014, regwdata, memrdata, dmcreq, dmcaddr,
        output dmahalt, dmaaddr, dmard, dmawr2004, dmawdata, dmcack, dmcdata
    );
`else
    modport master (
        output cputick, wr4014, regwdata, memrdata,
        input  dmahalt, dmaaddr, dmard, dmawr2004, dmawdata
    );
    modport slave (
        input  cputick, wr4014, regwdata, memrdata,
        output dmahalt, dmaaddr, dmard, dmawr2004, dmawdata
    );
`endif
endinterface

// File: rtl/oamdma.sv
// $4014 sprite DMA: halts the CPU and copies one CPU page into OAM via $2004 strobes.
// Define OAMDMA_DMC_EN to let DMC sample fetches steal get slots.
module oamdma
    import oamdma_pkg::*;
#(
    parameter int unsigned NBYTES = NBYTES_DEF
) (
    input  logic   clk,
    input  logic   reset,
    oamdma_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(NBYTES);

    state_e             r_state;
    logic               r_parity;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_page;
    logic [7:0]         r_data;
    state_e             w_get_state;
    logic               w_start;
    logic [15:0]        w_oam_addr;

`ifdef OAMDMA_DMC_EN
    logic               r_active;
    logic [7:0]         r_dmcdata;

    assign w_start = bus.wr4014 | bus.dmcreq;

    // A pending DMC fetch wins the get slot; with no OAM transfer open, fall back to idle.
    always_comb begin
        w_get_state = ST_READ;
        if (bus.dmcreq) begin
            w_get_state = ST_DMCRD;
        end else if (!r_active) begin
            w_get_state = ST_IDLE;
        end
    end
`else
    assign w_start = bus.wr4014;

    always_comb begin
        w_get_state = ST_READ;
    end
`endif

    assign w_oam_addr = 16'({r_page, 8'h00}) | 16'(r_cnt);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_parity <= 1'b0;
            r_cnt    <= '0;
            r_page   <= 8'h00;
            r_data   <= 8'h00;
`ifdef OAMDMA_DMC_EN
            r_active  <= 1'b0;
            r_dmcdata <= 8'h00;
`endif
        end else if (bus.cputick) begin
            r_parity <= ~r_parity;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_HALT;
                        if (bus.wr4014) begin
                            r_page <= bus.regwdata;
                            r_cnt  <= '0;
                        end
`ifdef OAMDMA_DMC_EN
                        r_active <= bus.wr4014;
`endif
                    end
                end
                // Current cycle is put when parity is 1, so the next one is a get.
                ST_HALT:  r_state <= r_parity ? w_get_state : ST_ALIGN;
                ST_ALIGN: r_state <= w_get_state;
                ST_READ: begin
                    r_data  <= bus.memrdata;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(NBYTES - 1)) begin
                        r_state <= ST_IDLE;
`ifdef OAMDMA_DMC_EN
                        r_active <= 1'b0;
`endif
                    end else begin
                        r_state <= w_get_state;
                    end
                end
`ifdef OAMDMA_DMC_EN
                ST_DMCRD: begin
                    r_dmcdata <= bus.memrdata;
                    r_state   <= r_active ? ST_DMCPUT : ST_IDLE;
                end
                ST_DMCPUT: r_state <= w_get_state;
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output decode from the registered state; strobes are gated by reset so an abort emits nothing.
    assign bus.dmahalt   = (r_state != ST_IDLE);
    assign bus.dmawr2004 = (r_state == ST_WRITE) && bus.cputick && reset;
    assign bus.dmawdata  = r_data;
`ifdef OAMDMA_DMC_EN
    assign bus.dmard   = (r_state == ST_READ) || (r_state == ST_DMCRD);
    assign bus.dmaaddr = (r_state == ST_READ)  ? w_oam_addr :
                         (r_state == ST_DMCRD) ? bus.dmcaddr : 16'h0000;
    assign bus.dmcack  = (r_state == ST_DMCRD) && bus.cputick && reset;
    assign bus.dmcdata = r_dmcdata;
`else
    assign bus.dmard   = (r_state == ST_READ);
    assign bus.dmaaddr = (r_state == ST_READ) ? w_oam_addr : 16'h0000;
`endif

endmodule
